// File: rtl/bitbakery_serial_tx_ctrl_if.sv
// bitbakery_serial_tx_ctrl_if: groups the request, game-state, snapshot and pacing signals of the packet sequencer.
//   master: request side (enviar, auto_en, D0-D2, map_obstacles, fim_tx out; snapshots, pulses, status in)
//   slave:  sequencer side (mirror of master)
interface bitbakery_serial_tx_ctrl_if;
    logic         enviar;
    logic         auto_en;
    logic [7:0]   D0;
    logic [7:0]   D1;
    logic [7:0]   D2;
    logic [511:0] map_obstacles;
    logic         fim_tx;
    logic [7:0]   D0_q;
    logic [7:0]   D1_q;
    logic [7:0]   D2_q;
    logic [511:0] map_q;
    logic         iniciar;
    logic         conta;
    logic         ocupado;
    logic         fim_pacote;
    logic [3:0]   db_estado;

    modport master (
        output enviar, auto_en, D0, D1, D2, map_obstacles, fim_tx,
        input  D0_q, D1_q, D2_q, map_q, iniciar, conta, ocupado, fim_pacote, db_estado
    );

    modport slave (
        input  enviar, auto_en, D0, D1, D2, map_obstacles, fim_tx,
        output D0_q, D1_q, D2_q, map_q, iniciar, conta, ocupado, fim_pacote, db_estado
    );
endinterface

// File: rtl/bitbakery_serial_tx_ctrl.sv
// bitbakery_serial_tx_ctrl: snapshots game state and paces the transmitter through one 69-byte packet per request.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : slave modport; requests, live state and fim_tx in; snapshots, iniciar/conta/fim_pacote pulses, ocupado, db_estado out
module bitbakery_serial_tx_ctrl #(
    parameter int N_BYTES = 69,
    parameter int PERIODO = 2500000
) (
    input logic                       clock,
    input logic                       reset,
    bitbakery_serial_tx_ctrl_if.slave bus
);
    localparam int TW = $clog2(PERIODO);
    localparam logic [TW-1:0] T_MAX = TW'(PERIODO - 1);
    localparam logic [6:0] LAST = 7'(N_BYTES - 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        TRANSMITE = 4'd2,
        ESPERA    = 4'd3,
        PROXIMO   = 4'd4,
        FIM       = 4'd5
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pendente_q, pendente_d;
    logic          wrap;
    logic          load;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            INICIAL:   state_d = (bus.enviar || pendente_q) ? PREPARA : INICIAL;
            PREPARA: begin
                load    = 1'b1;
                idx_d   = 7'd0;
                state_d = TRANSMITE;
            end
            TRANSMITE: state_d = ESPERA;
            ESPERA:    state_d = !bus.fim_tx ? ESPERA : (idx_q == LAST) ? FIM : PROXIMO;
            PROXIMO: begin
                idx_d   = idx_q + 7'd1;
                state_d = TRANSMITE;
            end
            FIM: begin
                idx_d   = 7'd0;
                state_d = INICIAL;
            end
            default:   state_d = INICIAL;
        endcase
    end

    // A request arriving while a packet is in flight (or a timer wrap) is remembered
    // once; accepting a packet consumes it, so coincident requests collapse.
    always_comb begin
        wrap       = bus.auto_en && (timer_q == T_MAX);
        timer_d    = (!bus.auto_en || wrap) ? '0 : timer_q + TW'(1);
        pendente_d = (state_q == INICIAL && state_d == PREPARA) ? 1'b0 :
                     pendente_q || wrap || (bus.enviar && state_q != INICIAL);
    end

    always_comb begin
        bus.iniciar    = state_q == TRANSMITE;
        bus.conta      = state_q == PROXIMO || state_q == FIM;
        bus.fim_pacote = state_q == FIM;
        bus.ocupado    = state_q != INICIAL;
        bus.db_estado  = state_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= INICIAL;
            idx_q      <= 7'd0;
            timer_q    <= '0;
            pendente_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            pendente_q <= pendente_d;
        end
    end

    // Snapshot is taken on the edge leaving PREPARA and held for the whole packet.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.D0_q  <= 8'd0;
            bus.D1_q  <= 8'd0;
            bus.D2_q  <= 8'd0;
            bus.map_q <= '0;
        end else if (load) begin
            bus.D0_q  <= bus.D0;
            bus.D1_q  <= bus.D1;
            bus.D2_q  <= bus.D2;
            bus.map_q <= bus.map_obstacles;
        end
    end
endmodule

// File: tb/tb_bitbakery_serial_tx_ctrl.sv
// tb_bitbakery_serial_tx_ctrl: directed bench with a transmitter model (byte counter mod 69, fim_tx after a delay).
module tb_bitbakery_serial_tx_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bitbakery_serial_tx_ctrl_if bus();
    bitbakery_serial_tx_ctrl #(.N_BYTES(69), .PERIODO(500)) dut (.clock(clock), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic fim_m = 1'b0;
    logic fim_s = 1'b0;
    assign bus.fim_tx = fim_m | fim_s;

    int dly = 20;
    int cnt = 0, cd = 0, n_ini = 0, n_conta = 0, n_pkt = 0, n_rec = 0, n_prep = 0, bad_fp = 0, cyc = 0;
    int prep_c [0:15];
    logic [7:0] seq [0:1023];
    logic [511:0] pat_map;

    // Transmitter model: selects the byte from the snapshots using its own counter.
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            cnt = 0;
            cd = 0;
            fim_m = 1'b0;
        end else begin
            fim_m = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) fim_m = 1'b1;
            end
            if (bus.iniciar) begin
                seq[n_rec % 1024] = cnt == 0 ? 8'hFF : cnt == 1 ? bus.D0_q : cnt == 2 ? bus.D1_q :
                                    cnt == 3 ? bus.D2_q : cnt == 68 ? 8'hFE : bus.map_q[8*(cnt-4) +: 8];
                n_rec++;
                n_ini++;
                cd = dly;
            end
            if (bus.conta) begin
                n_conta++;
                cnt = (cnt == 68) ? 0 : cnt + 1;
            end
            if (bus.fim_pacote) begin
                n_pkt++;
                if (!bus.conta) bad_fp++;
            end
            if (bus.db_estado == 4'd1) begin
                prep_c[n_prep % 16] = cyc;
                n_prep++;
            end
        end
    end

    function automatic int seq_errs(input int base, input logic [7:0] e0, input logic [7:0] e1,
                                    input logic [7:0] e2, input logic [511:0] m);
        int e = 0;
        logic [7:0] x;
        for (int i = 0; i < 69; i++) begin
            x = i == 0 ? 8'hFF : i == 1 ? e0 : i == 2 ? e1 : i == 3 ? e2 : i == 68 ? 8'hFE : m[8*(i-4) +: 8];
            if (seq[(base + i) % 1024] !== x) e++;
        end
        return e;
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic send();
        step();
        bus.enviar = 1'b1;
        step();
        bus.enviar = 1'b0;
    endtask

    task automatic wait_pkt(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_pkt >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step();
        tests++;
        if ({bus.iniciar, bus.conta, bus.ocupado, bus.fim_pacote} !== 4'b0) begin
            fails++;
            $display("FAIL reset_pulses: got %b expected 0000", {bus.iniciar, bus.conta, bus.ocupado, bus.fim_pacote});
        end
        tests++;
        if (bus.db_estado !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d expected 0", bus.db_estado);
        end
        tests++;
        if ({bus.D0_q, bus.D1_q, bus.D2_q, bus.map_q} !== '0) begin
            fails++;
            $display("FAIL reset_snapshot: got D0_q=%h D1_q=%h D2_q=%h expected all 0", bus.D0_q, bus.D1_q, bus.D2_q);
        end
        tests++;
        if ({dut.timer_q, dut.pendente_q} !== '0) begin
            fails++;
            $display("FAIL reset_timer: got timer=%0d pendente=%b expected 0/0", dut.timer_q, dut.pendente_q);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_packet();
        int bi = n_ini, bc = n_conta, bp = n_pkt, br = n_rec, bf = bad_fp;
        bit ok;
        dly = 20;
        send();
        tests++;
        if (bus.db_estado !== 4'd1) begin
            fails++;
            $display("FAIL sp_prepara: got state %0d expected 1", bus.db_estado);
        end
        step();
        tests++;
        if ({bus.iniciar, bus.D0_q, bus.db_estado} !== {1'b1, 8'h12, 4'd2}) begin
            fails++;
            $display("FAIL sp_first_iniciar: got iniciar=%b D0_q=%h state=%0d expected 1/12/2", bus.iniciar, bus.D0_q, bus.db_estado);
        end
        wait_pkt(bp + 1, 3000, ok);
        tests++;
        if (!ok || bus.ocupado !== 1'b1) begin
            fails++;
            $display("FAIL sp_done: got done=%b ocupado=%b expected 1/1", ok, bus.ocupado);
        end
        tests++;
        if ((n_ini - bi) !== 69 || (n_conta - bc) !== 69) begin
            fails++;
            $display("FAIL sp_counts: got iniciar=%0d conta=%0d expected 69/69", n_ini - bi, n_conta - bc);
        end
        tests++;
        if (seq_errs(br, 8'h12, 8'h34, 8'h56, pat_map) !== 0) begin
            fails++;
            $display("FAIL sp_sequence: got %0d wrong bytes expected 0", seq_errs(br, 8'h12, 8'h34, 8'h56, pat_map));
        end
        tests++;
        if (cnt !== 0 || bad_fp !== bf) begin
            fails++;
            $display("FAIL sp_wrap: got tx_cnt=%0d lone_fim_pacote=%0d expected 0/0", cnt, bad_fp - bf);
        end
        step();
        tests++;
        if ({bus.ocupado, bus.db_estado, n_pkt - bp} !== {1'b0, 4'd0, 32'd1}) begin
            fails++;
            $display("FAIL sp_idle: got ocupado=%b state=%0d packets=%0d expected 0/0/1", bus.ocupado, bus.db_estado, n_pkt - bp);
        end
    endtask

    task automatic test_snapshot_hold();
        int bi = n_ini, bp = n_pkt, br = n_rec;
        bit ok = 1'b0;
        dly = 1;
        send();
        for (int i = 0; i < 500 && !ok; i++) begin
            step();
            ok = (n_ini - bi) >= 11;
        end
        bus.D0 = 8'h99;
        step();
        tests++;
        if (!ok || bus.D0_q !== 8'h12) begin
            fails++;
            $display("FAIL sh_hold: got reached=%b D0_q=%h expected 1/12", ok, bus.D0_q);
        end
        wait_pkt(bp + 1, 1000, ok);
        tests++;
        if (!ok || seq_errs(br, 8'h12, 8'h34, 8'h56, pat_map) !== 0) begin
            fails++;
            $display("FAIL sh_first_packet: got done=%b bad=%0d expected 1/0", ok, seq_errs(br, 8'h12, 8'h34, 8'h56, pat_map));
        end
        step();
        br = n_rec;
        send();
        wait_pkt(bp + 2, 1000, ok);
        tests++;
        if (!ok || seq_errs(br, 8'h99, 8'h34, 8'h56, pat_map) !== 0) begin
            fails++;
            $display("FAIL sh_next_packet: got done=%b bad=%0d expected 1/0", ok, seq_errs(br, 8'h99, 8'h34, 8'h56, pat_map));
        end
        step();
    endtask

    task automatic test_request_collapse();
        int bp = n_pkt, bi = n_ini;
        bit ok;
        dly = 1;
        send();
        repeat (20) step();
        send();
        repeat (30) step();
        send();
        repeat (30) step();
        send();
        wait_pkt(bp + 1, 1000, ok);
        step();
        tests++;
        if (!ok || bus.db_estado !== 4'd0) begin
            fails++;
            $display("FAIL rc_gap: got done=%b state=%0d expected 1/0", ok, bus.db_estado);
        end
        step();
        tests++;
        if (bus.db_estado !== 4'd1) begin
            fails++;
            $display("FAIL rc_back_to_back: got state %0d expected 1", bus.db_estado);
        end
        wait_pkt(bp + 2, 1000, ok);
        repeat (400) step();
        tests++;
        if ({n_pkt - bp, n_ini - bi} !== {32'd2, 32'd138}) begin
            fails++;
            $display("FAIL rc_count: got packets=%0d iniciar=%0d expected 2/138", n_pkt - bp, n_ini - bi);
        end
        tests++;
        if ({bus.db_estado, dut.pendente_q} !== {4'd0, 1'b0}) begin
            fails++;
            $display("FAIL rc_idle: got state=%0d pendente=%b expected 0/0", bus.db_estado, dut.pendente_q);
        end
    endtask

    task automatic test_periodic();
        int bn = n_prep, c0, bn2;
        bit ok = 1'b0;
        dly = 1;
        step();
        c0 = cyc;
        bus.auto_en = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step();
            ok = (n_prep - bn) >= 3;
        end
        bus.auto_en = 1'b0;
        tests++;
        if (!ok || prep_c[bn % 16] - c0 !== 501) begin
            fails++;
            $display("FAIL per_first: got seen=%b offset=%0d expected 1/501", ok, prep_c[bn % 16] - c0);
        end
        tests++;
        if (prep_c[(bn+1) % 16] - prep_c[bn % 16] !== 500 || prep_c[(bn+2) % 16] - prep_c[(bn+1) % 16] !== 500) begin
            fails++;
            $display("FAIL per_spacing: got %0d and %0d expected 500 and 500",
                     prep_c[(bn+1) % 16] - prep_c[bn % 16], prep_c[(bn+2) % 16] - prep_c[(bn+1) % 16]);
        end
        step();
        tests++;
        if (dut.timer_q !== '0) begin
            fails++;
            $display("FAIL per_timer_clear: got %0d expected 0", dut.timer_q);
        end
        bn2 = n_prep;
        repeat (1200) step();
        tests++;
        if (n_prep - bn2 !== 0 || bus.db_estado !== 4'd0) begin
            fails++;
            $display("FAIL per_stop: got new_packets=%0d state=%0d expected 0/0", n_prep - bn2, bus.db_estado);
        end
    endtask

    task automatic test_stray_fim();
        int bc = n_conta, bp = n_pkt;
        bit ok;
        dly = 20;
        fim_s = 1'b1;
        step();
        fim_s = 1'b0;
        step();
        tests++;
        if (bus.db_estado !== 4'd0 || n_conta !== bc) begin
            fails++;
            $display("FAIL sf_inicial: got state=%0d conta=%0d expected 0/0", bus.db_estado, n_conta - bc);
        end
        send();
        step();
        fim_s = 1'b1;
        step();
        fim_s = 1'b0;
        repeat (3) step();
        tests++;
        if (bus.db_estado !== 4'd3 || n_conta !== bc) begin
            fails++;
            $display("FAIL sf_transmite: got state=%0d conta=%0d expected 3/0", bus.db_estado, n_conta - bc);
        end
        wait_pkt(bp + 1, 3000, ok);
        tests++;
        if (!ok || n_conta - bc !== 69) begin
            fails++;
            $display("FAIL sf_packet: got done=%b conta=%0d expected 1/69", ok, n_conta - bc);
        end
        step();
    endtask

    task automatic test_reset_mid_packet();
        int bi = n_ini, bp, br;
        bit ok = 1'b0;
        dly = 1;
        send();
        for (int i = 0; i < 500 && !ok; i++) begin
            step();
            ok = (n_ini - bi) >= 31;
        end
        reset = 1'b0;
        step();
        tests++;
        if (!ok || {bus.iniciar, bus.conta, bus.ocupado, bus.fim_pacote, bus.db_estado} !== 8'd0) begin
            fails++;
            $display("FAIL rm_outputs: got reached=%b pulses=%b state=%0d expected 1/0000/0", ok,
                     {bus.iniciar, bus.conta, bus.ocupado, bus.fim_pacote}, bus.db_estado);
        end
        tests++;
        if ({bus.D0_q, bus.map_q} !== '0) begin
            fails++;
            $display("FAIL rm_snapshot: got D0_q=%h expected 00 with map_q 0", bus.D0_q);
        end
        reset = 1'b1;
        step();
        bi = n_ini;
        bp = n_pkt;
        br = n_rec;
        send();
        wait_pkt(bp + 1, 1000, ok);
        tests++;
        if (!ok || n_ini - bi !== 69 || seq_errs(br, 8'h99, 8'h34, 8'h56, pat_map) !== 0) begin
            fails++;
            $display("FAIL rm_recover: got done=%b iniciar=%0d bad=%0d expected 1/69/0", ok, n_ini - bi,
                     seq_errs(br, 8'h99, 8'h34, 8'h56, pat_map));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) pat_map[8*i +: 8] = (i % 2) ? 8'h55 : 8'hAA;
        bus.enviar = 1'b0;
        bus.auto_en = 1'b0;
        bus.D0 = 8'h12;
        bus.D1 = 8'h34;
        bus.D2 = 8'h56;
        bus.map_obstacles = pat_map;
        test_reset();
        test_single_packet();
        test_snapshot_hold();
        test_request_collapse();
        test_periodic();
        test_stray_fim();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
